mul_acc_collector: RTL

MUL_ACC_COLLECTOR -- requirements
Module: mul_acc_collector

---
 rtl/mul_pkg.sv | 17 +
 rtl/mul_acc_collector_if.sv | 30 +++
 rtl/prod_fifo.sv | 66 ++++++
 rtl/mul_acc_collector.sv | 114 +++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared constants and FSM encoding for the product collector.
// Imported by the interface, the FIFO and the top.
package mul_pkg;

  localparam int SIZE       = 8;
  localparam int LEN_W      = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int ACC_W      = 2*SIZE + LEN_W;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_acc_collector_if.sv
// Product input, length config and result handshake of the collector.
// The master drives products and acc_ready; the slave returns results.
interface mul_acc_collector_if
  import mul_pkg::*;
#(
  parameter int P_SIZE  = SIZE,
  parameter int P_LEN_W = LEN_W,
  parameter int P_DEPTH = FIFO_DEPTH
) ();

  logic                        mul_en_out;
  logic [2*P_SIZE-1:0]         mul_out;
  logic [P_LEN_W-1:0]          cfg_len;
  logic                        acc_ready;
  logic                        acc_valid;
  logic [2*P_SIZE+P_LEN_W-1:0] acc_out;
  logic                        ovf;
  logic [$clog2(P_DEPTH):0]    fifo_level;

  modport master (
    output mul_en_out, mul_out, cfg_len, acc_ready,
    input  acc_valid, acc_out, ovf, fifo_level
  );

  modport slave (
    input  mul_en_out, mul_out, cfg_len, acc_ready,
    output acc_valid, acc_out, ovf, fifo_level
  );

endinterface

// File: rtl/prod_fifo.sv
// Synchronous product buffer; a push into a full FIFO lands only
// if a pop frees a slot in the same cycle.
module prod_fifo
  import mul_pkg::*;
#(
  parameter int W     = 2*SIZE,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH-1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == LW'(DEPTH));
  assign level_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = (wr_q == LAST) ? '0 : wr_q + 1'b1;
    if (do_pop)  rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/mul_acc_collector.sv
// Collects multiplier products into dot-product sums of a configured
// length and hands each sum downstream over a valid/ready handshake.
module mul_acc_collector
  import mul_pkg::*;
#(
  parameter int SIZE       = mul_pkg::SIZE,
  parameter int LEN_W      = mul_pkg::LEN_W,
  parameter int FIFO_DEPTH = mul_pkg::FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  mul_acc_collector_if.slave bus
);

  localparam int PW = 2*SIZE;
  localparam int AW = 2*SIZE + LEN_W;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LEN_W:0] ONE = {{LEN_W{1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [LEN_W:0]  cnt_q, cnt_d;
  logic [LEN_W:0]  len_q, len_d;
  logic [LEN_W:0]  eff_len, cnt_inc;
  logic [AW-1:0]   prod;
  logic [PW-1:0]   head;
  logic [LW-1:0]   level;
  logic            pop, start, empty, full, drop;
  logic            ovf_q, ovf_d;

  prod_fifo #(
    .W     (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.mul_en_out),
    .pop_i   (pop),
    .din_i   (bus.mul_out),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  // cfg_len of zero stands for the maximum length 2**LEN_W
  assign eff_len = (bus.cfg_len == '0) ? {1'b1, {LEN_W{1'b0}}}
                                       : {1'b0, bus.cfg_len};
  assign prod    = {{LEN_W{1'b0}}, head};
  assign cnt_inc = cnt_q + 1'b1;

  assign start = !empty &&
                 ((state_q == ST_IDLE) ||
                  (state_q == ST_DONE && bus.acc_ready));

  assign drop  = bus.mul_en_out && full && !pop;
  assign ovf_d = ovf_q | drop;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_ACC: begin
        if (!empty) begin
          pop   = 1'b1;
          acc_d = acc_q + prod;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.acc_ready) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      pop     = 1'b1;
      acc_d   = prod;
      cnt_d   = ONE;
      len_d   = eff_len;
      state_d = (eff_len == ONE) ? ST_DONE : ST_ACC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.acc_valid  = (state_q == ST_DONE);
  assign bus.acc_out    = acc_q;
  assign bus.ovf        = ovf_q;
  assign bus.fifo_level = level;

endmodule
